// File: rtl/b_nand_pkg.sv
// rtl/b_nand_pkg.sv - default sizing constants for the b_nand leaf cell
package b_nand_pkg;

    localparam int B_NAND_WIDTH = 1;
    localparam int B_NAND_CNT_W = 16;

endpackage

// File: rtl/b_nand.sv
// rtl/b_nand.sv - bitwise NAND with combinational result, registered copy and saturating toggle counter
module b_nand
    import b_nand_pkg::*;
#(
    parameter int WIDTH = B_NAND_WIDTH,
    parameter int CNT_W = B_NAND_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_r,
    output logic [CNT_W-1:0] toggle_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    assign y = ~(a & b);

    // Reset value of y_r is the NAND of all-zero inputs, so leaving reset
    // with idle inputs does not register a toggle.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_r        <= '1;
            toggle_cnt <= '0;
        end else begin
            y_r <= y;
            if ((y != y_r) && (toggle_cnt != CNT_MAX)) begin
                toggle_cnt <= toggle_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_b_nand.sv
// tb/tb_b_nand.sv - self-checking bench for b_nand at widths 1, 4 and 8
module tb_b_nand;

    logic clk = 1'b0;
    logic rst;
    logic [0:0]  a1, b1, y1, y1_r;
    logic [3:0]  a4, b4, y4, y4_r;
    logic [7:0]  a8, b8, y8, y8_r;
    logic [15:0] c1, c4;
    logic [2:0]  c8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    b_nand #(.WIDTH(1), .CNT_W(16)) u1 (.clk(clk), .rst(rst), .a(a1), .b(b1), .y(y1), .y_r(y1_r), .toggle_cnt(c1));
    b_nand #(.WIDTH(4), .CNT_W(16)) u4 (.clk(clk), .rst(rst), .a(a4), .b(b4), .y(y4), .y_r(y4_r), .toggle_cnt(c4));
    b_nand #(.WIDTH(8), .CNT_W(3))  u8 (.clk(clk), .rst(rst), .a(a8), .b(b8), .y(y8), .y_r(y8_r), .toggle_cnt(c8));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: remembers last sampled result and counts value changes, clamped.
    logic [0:0] m1_yr;
    logic [3:0] m4_yr;
    logic [7:0] m8_yr;
    int m1_c, m4_c, m8_c;
    bit mvalid = 0;

    function automatic int bump(input int c, input bit changed, input int max);
        if (!changed) return c;
        return (c >= max) ? max : c + 1;
    endfunction

    always @(posedge clk) begin
        logic [0:0] n1;
        logic [3:0] n4;
        logic [7:0] n8;
        n1 = ~(a1 & b1);
        n4 = ~(a4 & b4);
        n8 = ~(a8 & b8);
        if (rst) begin
            m1_yr = '1; m4_yr = '1; m8_yr = '1;
            m1_c = 0; m4_c = 0; m8_c = 0;
            mvalid = 1;
        end else if (mvalid) begin
            m1_c = bump(m1_c, n1 != m1_yr, 65535);
            m4_c = bump(m4_c, n4 != m4_yr, 65535);
            m8_c = bump(m8_c, n8 != m8_yr, 7);
            m1_yr = n1; m4_yr = n4; m8_yr = n8;
        end
    end

    always @(negedge clk) begin
        logic [0:0] e1;
        logic [3:0] e4;
        logic [7:0] e8;
        if (mvalid) begin
            e1 = ~(a1 & b1);
            e4 = ~(a4 & b4);
            e8 = ~(a8 & b8);
            check("cyc_y1", 32'(y1), 32'(e1));
            check("cyc_y4", 32'(y4), 32'(e4));
            check("cyc_y8", 32'(y8), 32'(e8));
            check("cyc_y1_r", 32'(y1_r), 32'(m1_yr));
            check("cyc_y4_r", 32'(y4_r), 32'(m4_yr));
            check("cyc_y8_r", 32'(y8_r), 32'(m8_yr));
            check("cyc_cnt1", 32'(c1), 32'(m1_c));
            check("cyc_cnt4", 32'(c4), 32'(m4_c));
            check("cyc_cnt8", 32'(c8), 32'(m8_c));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [2:0] seq [6] = '{3'b101, 3'b110, 3'b011, 3'b101, 3'b110, 3'b001};
    logic [2:0] tt  [4] = '{3'b001, 3'b101, 3'b110, 3'b011};

    initial begin
        rst = 1'b1;
        a1 = '0; b1 = '0; a4 = '0; b4 = '0; a8 = '0; b8 = '0;
        repeat (2) step();
        check("reset_y1_r", 32'(y1_r), 32'h1);
        check("reset_y4_r", 32'(y4_r), 32'hF);
        check("reset_cnt4", 32'(c4), 32'h0);
        rst = 1'b0;

        // truth table, no clock dependency
        foreach (tt[i]) begin
            a1 = tt[i][2]; b1 = tt[i][1];
            #1;
            check("truth_y", 32'(y1), 32'(tt[i][0]));
        end
        step();

        foreach (seq[i]) begin
            a1 = seq[i][2]; b1 = seq[i][1];
            #1;
            check("seq_y", 32'(y1), 32'(seq[i][0]));
            #9;
        end
        step();

        a1 = 1'b1; b1 = 1'b1;
        repeat (3) step();
        check("pre_rst_y1_r", 32'(y1_r), 32'h0);
        rst = 1'b1;
        step();
        check("rst_y1_r", 32'(y1_r), 32'h1);
        check("rst_cnt1", 32'(c1), 32'h0);
        check("rst_y1", 32'(y1), 32'h0);
        rst = 1'b0;
        #1;
        check("post_rst_y1", 32'(y1), 32'h0);

        // u4 toggles for 10 edges then holds; u8 toggles 12 edges into saturation
        for (int k = 1; k <= 12; k++) begin
            if (k <= 10) begin
                a4 = (k % 2) ? 4'hF : 4'h0;
                b4 = a4;
            end
            a8 = (k % 2) ? 8'hFF : 8'h00;
            b8 = a8;
            step();
            check("sat_cnt8", 32'(c8), (k < 7) ? 32'(k) : 32'd7);
            if (k <= 10) check("tog_cnt4", 32'(c4), 32'(k));
        end
        repeat (3) step();
        check("hold_cnt4", 32'(c4), 32'd10);
        check("hold_y4_r", 32'(y4_r), 32'hF);

        a8 = 8'hA5; b8 = 8'h3C;
        #1;
        check("mb_y", 32'(y8), 32'hDB);
        step();
        check("mb_y_r", 32'(y8_r), 32'hDB);
        check("mb_cnt8_sat", 32'(c8), 32'd7);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
